wordline_addr_seq: RTL and testbench

WORDLINE_ADDR_SEQ -- requirements
Module: wordline_addr_seq

---
 rtl/wordline_pkg.sv | 19 +
 rtl/wordline_cmd_reg.sv | 51 +++++
 rtl/wordline_addr_seq.sv | 168 ++++++++++++++++
 tb/tb_wordline_addr_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wordline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wordline_pkg
//  Description : Mode and state encodings shared by the wordline sequencer.
//  Revision    : 1.0
// ============================================================================
package wordline_pkg;

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wordline_cmd_reg.sv
`default_nettype none
// ============================================================================
//  Module      : wordline_cmd_reg
//  Description : One-entry pending command register (valid + start/len/mode).
//  Revision    : 1.0
// ============================================================================
module wordline_cmd_reg #(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [1:0]        i_mode,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_start,
    output logic [LEN_W-1:0]  o_len,
    output logic [1:0]        o_mode
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_start;
    logic [LEN_W-1:0]  r_len;
    logic [1:0]        r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_start <= '0;
            r_len   <= '0;
            r_mode  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_start <= i_start;
            r_len   <= i_len;
            r_mode  <= i_mode;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_start = r_start;
    assign o_len   = r_len;
    assign o_mode  = r_mode;

endmodule
`default_nettype wire

// File: rtl/wordline_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wordline_addr_seq
//  Description : Burst address sequencer feeding a one-hot wordline decoder.
//  Revision    : 1.0
// ============================================================================
module wordline_addr_seq
    import wordline_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [1:0]        cmd_mode,
    input  logic              stall,
    output logic [ADDR_W-1:0] A,
    output logic              a_valid,
    output logic              last,
    output logic              busy,
    output logic              done
);

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [ADDR_W-1:0] r_start, w_start_nx;
    logic [LEN_W-1:0]  r_remain, w_remain_nx;
    logic [1:0]        r_mode, w_mode_nx;
    logic              r_valid, w_valid_nx;
    logic              r_done, w_done_nx;
    logic              r_zdone, w_zdone_nx;

    logic              w_pend_valid, w_pend_load, w_pend_clear;
    logic [ADDR_W-1:0] w_pend_start;
    logic [LEN_W-1:0]  w_pend_len;
    logic [1:0]        w_pend_mode;

    logic              w_accept, w_consume, w_is_last;
    logic              w_ld_en;
    logic [ADDR_W-1:0] w_ld_start;
    logic [LEN_W-1:0]  w_ld_len;
    logic [1:0]        w_ld_mode;

    wordline_cmd_reg #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_pend (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_pend_load),
        .i_clear (w_pend_clear),
        .i_start (cmd_start),
        .i_len   (cmd_len),
        .i_mode  (cmd_mode),
        .o_valid (w_pend_valid),
        .o_start (w_pend_start),
        .o_len   (w_pend_len),
        .o_mode  (w_pend_mode)
    );

    assign cmd_ready = ~w_pend_valid;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_consume = r_valid & ~stall;
    assign w_is_last = (r_remain == LEN_W'(1));

    always_comb begin
        w_state_nx   = r_state;
        w_addr_nx    = r_addr;
        w_start_nx   = r_start;
        w_remain_nx  = r_remain;
        w_mode_nx    = r_mode;
        w_valid_nx   = r_valid;
        w_done_nx    = 1'b0;
        w_zdone_nx   = 1'b0;
        w_pend_load  = 1'b0;
        w_pend_clear = 1'b0;
        w_ld_en      = 1'b0;
        w_ld_start   = cmd_start;
        w_ld_len     = cmd_len;
        w_ld_mode    = cmd_mode;

        if (w_consume && w_is_last) begin
            w_done_nx = 1'b1;
            if (w_pend_valid) begin
                w_ld_en      = 1'b1;
                w_ld_start   = w_pend_start;
                w_ld_len     = w_pend_len;
                w_ld_mode    = w_pend_mode;
                w_pend_clear = 1'b1;
            end else if (w_accept) begin
                w_ld_en = 1'b1;
            end else begin
                w_valid_nx = 1'b0;
                w_state_nx = ST_IDLE;
            end
        end else begin
            if (w_consume) begin
                w_remain_nx = r_remain - LEN_W'(1);
                case (r_mode)
                    MODE_DEC:  w_addr_nx = r_addr - ADDR_W'(1);
                    MODE_HOLD: w_addr_nx = r_start;
                    default:   w_addr_nx = r_addr + ADDR_W'(1);
                endcase
            end
            if (w_accept) begin
                if (r_state == ST_IDLE) begin
                    if (cmd_len == '0) w_done_nx = 1'b1;
                    else               w_ld_en   = 1'b1;
                end else begin
                    w_pend_load = 1'b1;
                end
            end
        end

        // A zero-length command taken at a burst boundary owes its own done
        // pulse, deferred one cycle so it does not merge with the burst's.
        if (r_zdone) w_done_nx = 1'b1;

        if (w_ld_en) begin
            if (w_ld_len == '0) begin
                w_valid_nx = 1'b0;
                w_state_nx = ST_IDLE;
                w_zdone_nx = 1'b1;
            end else begin
                w_addr_nx   = w_ld_start;
                w_start_nx  = w_ld_start;
                w_remain_nx = w_ld_len;
                w_mode_nx   = w_ld_mode;
                w_valid_nx  = 1'b1;
                w_state_nx  = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_start  <= '0;
            r_remain <= '0;
            r_mode   <= MODE_INC;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_zdone  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_addr   <= w_addr_nx;
            r_start  <= w_start_nx;
            r_remain <= w_remain_nx;
            r_mode   <= w_mode_nx;
            r_valid  <= w_valid_nx;
            r_done   <= w_done_nx;
            r_zdone  <= w_zdone_nx;
        end
    end

    assign A       = r_addr;
    assign a_valid = r_valid;
    assign last    = r_valid & w_is_last;
    assign busy    = (r_state == ST_RUN) | w_pend_valid;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wordline_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wordline_addr_seq
//  Description : Scoreboard bench for wordline_addr_seq with a one-hot decoder.
//  Revision    : 1.0
// ============================================================================
module tb_wordline_addr_seq;

    typedef struct packed {
        logic [4:0] addr;
        logic       last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_start;
    logic [5:0]  cmd_len;
    logic [1:0]  cmd_mode;
    logic        stall;
    logic [4:0]  A;
    logic        a_valid;
    logic        last;
    logic        busy;
    logic        done;
    logic [31:0] dec_out;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   vcount   = 0;
    logic exp_done = 1'b0;

    wordline_addr_seq #(
        .ADDR_W (5),
        .LEN_W  (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_mode  (cmd_mode),
        .stall     (stall),
        .A         (A),
        .a_valid   (a_valid),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    // 5-to-32 wordline decoder driven by the sequencer
    assign dec_out = 32'd1 << A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic       nd;
        exp_t       e;
        logic [4:0] a;
        if (reset) begin
            sb.delete();
            exp_done = 1'b0;
        end else begin
            check("done", 32'(done), 32'(exp_done));
            if (done) done_cnt++;
            if (a_valid) vcount++;
            if (sb.size() == 0) begin
                check("a_valid_idle", 32'(a_valid), 32'd0);
            end else begin
                check("a_valid", 32'(a_valid), 32'd1);
                check("addr", 32'(A), 32'(sb[0].addr));
                check("last", 32'(last), 32'(sb[0].last));
                check("decoder", dec_out, 32'd1 << sb[0].addr);
            end
            nd = 1'b0;
            if (sb.size() != 0 && a_valid && !stall && sb[0].last) nd = 1'b1;
            if (cmd_valid && cmd_ready && cmd_len == 6'd0) nd = 1'b1;
            if (sb.size() != 0 && a_valid && !stall) void'(sb.pop_front());
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i < int'(cmd_len); i++) begin
                    case (cmd_mode)
                        2'b01:   a = cmd_start - 5'(i);
                        2'b10:   a = cmd_start;
                        default: a = cmd_start + 5'(i);
                    endcase
                    e.addr = a;
                    e.last = (i == int'(cmd_len) - 1);
                    sb.push_back(e);
                end
            end
            exp_done = nd;
        end
    end

    task automatic send(input logic [4:0] s, input logic [5:0] l, input logic [1:0] m);
        cmd_valid = 1'b1;
        cmd_start = s;
        cmd_len   = l;
        cmd_mode  = m;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_start = 5'($urandom);
        cmd_len   = 6'($urandom);
        cmd_mode  = 2'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_len   = '0;
        cmd_mode  = '0;
        stall     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_A", 32'(A), 32'd0);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        done_cnt = 0;
        send(5'd3, 6'd4, 2'b00);
        wait_idle();
        check("inc_done_cnt", 32'(done_cnt), 32'd1);

        send(5'd1, 6'd3, 2'b01);
        wait_idle();
        send(5'd30, 6'd4, 2'b00);
        wait_idle();

        done_cnt = 0;
        send(5'd0, 6'd2, 2'b00);
        send(5'd10, 6'd2, 2'b00);
        check("pend_cmd_ready", 32'(cmd_ready), 32'd0);
        check("pend_busy", 32'(busy), 32'd1);
        wait_idle();
        check("b2b_done_cnt", 32'(done_cnt), 32'd2);

        vcount = 0;
        send(5'd5, 6'd3, 2'b00);
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1 stall = 1'b0;
        wait_idle();
        check("stall_vcount", 32'(vcount), 32'd5);

        send(5'd7, 6'd3, 2'b10);
        wait_idle();
        send(5'd31, 6'd2, 2'b11);
        wait_idle();
        done_cnt = 0;
        send(5'd20, 6'd1, 2'b00);
        send(5'd21, 6'd1, 2'b01);
        wait_idle();
        check("len1_done_cnt", 32'(done_cnt), 32'd2);
        send(5'd16, 6'd32, 2'b01);
        wait_idle();

        done_cnt = 0;
        vcount   = 0;
        send(5'd4, 6'd0, 2'b00);
        wait_idle();
        check("zero_done_cnt", 32'(done_cnt), 32'd1);
        check("zero_vcount", 32'(vcount), 32'd0);

        done_cnt = 0;
        send(5'd8, 6'd10, 2'b00);
        for (int k = 0; k < 50; k++) begin
            if (a_valid && A == 5'd11) break;
            @(posedge clk);
            #1;
        end
        check("reach_a11", 32'(A), 32'd11);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_A", 32'(A), 32'd0);
        check("abort_a_valid", 32'(a_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_last", 32'(last), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("abort_done_cnt", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
